// File: rtl/decimator_stream_pkg.sv
// Shared definitions for the decimator datapath and its controller.
package dsp_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        LAST    = 1'b1
    } dec_state_e;

    function automatic int phase_w(input int factor);
        return (factor > 1) ? $clog2(factor) : 1;
    endfunction

endpackage

// File: rtl/decimator_stream_if.sv
// Source and sink valid/ready sample streams of the decimator, bundled as one port.
interface decimator_stream_if #(
    parameter int DATA_W = 16
);
    logic              src_valid_in;
    logic              src_ready_out;
    logic [DATA_W-1:0] src_data_in;
    logic              dst_valid_out;
    logic              dst_ready_in;
    logic [DATA_W-1:0] dst_data_out;

    modport slave (
        input  src_valid_in,
        input  src_data_in,
        input  dst_ready_in,
        output src_ready_out,
        output dst_valid_out,
        output dst_data_out
    );

    modport master (
        output src_valid_in,
        output src_data_in,
        output dst_ready_in,
        input  src_ready_out,
        input  dst_valid_out,
        input  dst_data_out
    );
endinterface

// File: rtl/decimator_stream_ctrl.sv
// Group sequencer for the decimator: phase counter, output-valid flag and datapath strobes.
//
// state   | meaning
// COLLECT | phase 0..FACTOR-2, accepting samples into the accumulator
// LAST    | phase FACTOR-1, next accept completes the group and loads the output
module decimator_ctrl
    import dsp_pkg::*;
#(
    parameter  int FACTOR  = 2,
    localparam int PHASE_W = phase_w(FACTOR)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               src_valid_in,
    input  logic               dst_ready_in,
    input  logic               flush_in,
    output logic               src_ready_out,
    output logic               dst_valid_out,
    output logic [PHASE_W-1:0] phase_out,
    output logic               acc_load,
    output logic               acc_add,
    output logic               acc_clr,
    output logic               out_load
);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FACTOR - 1);

    dec_state_e         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               valid_q, valid_d;
    logic               accept;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= COLLECT;
            phase_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        valid_d  = valid_q;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        out_load = 1'b0;
        acc_clr  = flush_in;

        // Only the group-completing sample can be stalled by a full output register.
        src_ready_out = (state_q != LAST) | !valid_q | dst_ready_in;
        accept        = src_valid_in & src_ready_out & !flush_in;

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    acc_load = (phase_q == '0);
                    acc_add  = (phase_q != '0);
                    phase_d  = phase_q + PHASE_W'(1);
                    if (phase_d == PHASE_LAST) begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                if (accept) begin
                    out_load = 1'b1;
                    acc_clr  = 1'b1;
                    phase_d  = '0;
                    state_d  = COLLECT;
                end
            end
        endcase

        if (flush_in) begin
            phase_d = '0;
            state_d = COLLECT;
        end

        // A completion in the same cycle as a transfer reloads without a bubble.
        if (valid_q && dst_ready_in) begin
            valid_d = 1'b0;
        end
        if (out_load) begin
            valid_d = 1'b1;
        end
    end

    assign dst_valid_out = valid_q;
    assign phase_out     = phase_q;

endmodule

// File: rtl/decimator_stream.sv
// Streaming decimate-by-FACTOR: keeps the first sample of each group (drop) or
// emits the floor boxcar mean of the group (average).
module decimator_stream
    import dsp_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int FACTOR  = 2,
    localparam int PHASE_W = phase_w(FACTOR)
) (
    input  logic               clk,
    input  logic               arst_n,
    decimator_stream_if.slave  bus,
    input  logic               avg_en_in,
    input  logic               flush_in,
    output logic [PHASE_W-1:0] phase_out
);

    localparam int ACC_W = DATA_W + PHASE_W;

    if ((FACTOR < 2) || (FACTOR > 256) || ((FACTOR & (FACTOR - 1)) != 0)) begin : g_bad_factor
        $error("decimator_stream: FACTOR must be a power of two in 2..256");
    end

    logic                    acc_load, acc_add, acc_clr, out_load;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic [DATA_W-1:0]       avg_data;
    logic [DATA_W-1:0]       hold_q, hold_d;
    logic [DATA_W-1:0]       out_q, out_d;
    logic                    mode_q, mode_d;

    decimator_ctrl #(
        .FACTOR (FACTOR)
    ) u_ctrl (
        .clk           (clk),
        .arst_n        (arst_n),
        .src_valid_in  (bus.src_valid_in),
        .dst_ready_in  (bus.dst_ready_in),
        .flush_in      (flush_in),
        .src_ready_out (bus.src_ready_out),
        .dst_valid_out (bus.dst_valid_out),
        .phase_out     (phase_out),
        .acc_load      (acc_load),
        .acc_add       (acc_add),
        .acc_clr       (acc_clr),
        .out_load      (out_load)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc_q  <= '0;
            hold_q <= '0;
            out_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            hold_q <= hold_d;
            out_q  <= out_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        sample_ext = {{PHASE_W{bus.src_data_in[DATA_W-1]}}, bus.src_data_in};
        sum        = acc_q + sample_ext;
        // Sum of FACTOR samples divided by FACTOR always fits back into DATA_W.
        avg_data   = DATA_W'(sum >>> PHASE_W);

        acc_d  = acc_q;
        hold_d = hold_q;
        out_d  = out_q;
        mode_d = mode_q;

        if (acc_load) begin
            mode_d = avg_en_in;
            acc_d  = sample_ext;
            if (!avg_en_in) begin
                hold_d = bus.src_data_in;
            end
        end
        if (acc_add && mode_q) begin
            acc_d = sum;
        end
        if (out_load) begin
            out_d = mode_q ? avg_data : hold_q;
        end
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    assign bus.dst_data_out = out_q;

endmodule

// File: tb/tb_decimator_stream.sv
// Directed self-checking bench for decimator_stream with FACTOR=2 and FACTOR=4 instances.
module tb_decimator_stream;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       avg2 = 1'b0, flush2 = 1'b0;
    logic       avg4 = 1'b0, flush4 = 1'b0;
    logic [0:0] phase2;
    logic [1:0] phase4;
    int         tests_run = 0;
    int         tests_failed = 0;

    decimator_stream_if #(.DATA_W(16)) i2 ();
    decimator_stream_if #(.DATA_W(16)) i4 ();

    decimator_stream #(.DATA_W(16), .FACTOR(2)) dut2 (
        .clk       (clk),
        .arst_n    (arst_n),
        .bus       (i2),
        .avg_en_in (avg2),
        .flush_in  (flush2),
        .phase_out (phase2)
    );

    decimator_stream #(.DATA_W(16), .FACTOR(4)) dut4 (
        .clk       (clk),
        .arst_n    (arst_n),
        .bus       (i4),
        .avg_en_in (avg4),
        .flush_in  (flush4),
        .phase_out (phase4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i2.src_valid_in = 1'b0; i2.src_data_in = '0; i2.dst_ready_in = 1'b0;
        i4.src_valid_in = 1'b0; i4.src_data_in = '0; i4.dst_ready_in = 1'b0;
        arst_n = 1'b0;
        tick(); tick();
        tests_run++; if (i2.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid2: got %0b expected 0", i2.dst_valid_out); end
        tests_run++; if (i2.dst_data_out !== 16'd0) begin tests_failed++; $display("FAIL reset_data2: got %0d expected 0", i2.dst_data_out); end
        tests_run++; if (phase2 !== 1'b0) begin tests_failed++; $display("FAIL reset_phase2: got %0d expected 0", phase2); end
        arst_n = 1'b1;
        #1;
        tests_run++; if (i2.src_ready_out !== 1'b1) begin tests_failed++; $display("FAIL reset_ready2: got %0b expected 1", i2.src_ready_out); end
        tests_run++; if (i4.src_ready_out !== 1'b1) begin tests_failed++; $display("FAIL reset_ready4: got %0b expected 1", i4.src_ready_out); end
        tests_run++; if (phase4 !== 2'd0) begin tests_failed++; $display("FAIL reset_phase4: got %0d expected 0", phase4); end
        tests_run++; if (i4.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid4: got %0b expected 0", i4.dst_valid_out); end
        tick();
        tests_run++; if (i2.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL post_reset_valid2: got %0b expected 0", i2.dst_valid_out); end
    endtask

    task automatic test_drop_f2();
        avg2 = 1'b0; i2.dst_ready_in = 1'b1; i2.src_valid_in = 1'b1;
        i2.src_data_in = 16'd10; tick();
        tests_run++; if (phase2 !== 1'b1) begin tests_failed++; $display("FAIL drop_phase_a: got %0d expected 1", phase2); end
        tests_run++; if (i2.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL drop_valid_a: got %0b expected 0", i2.dst_valid_out); end
        tests_run++; if (i2.src_ready_out !== 1'b1) begin tests_failed++; $display("FAIL drop_ready_a: got %0b expected 1", i2.src_ready_out); end
        i2.src_data_in = 16'd20; tick();
        tests_run++; if (i2.dst_valid_out !== 1'b1) begin tests_failed++; $display("FAIL drop_valid_b: got %0b expected 1", i2.dst_valid_out); end
        tests_run++; if (i2.dst_data_out !== 16'd10) begin tests_failed++; $display("FAIL drop_data_b: got %0d expected 10", $signed(i2.dst_data_out)); end
        tests_run++; if (phase2 !== 1'b0) begin tests_failed++; $display("FAIL drop_phase_b: got %0d expected 0", phase2); end
        i2.src_data_in = 16'd30; tick();
        tests_run++; if (i2.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL drop_valid_c: got %0b expected 0", i2.dst_valid_out); end
        tests_run++; if (i2.src_ready_out !== 1'b1) begin tests_failed++; $display("FAIL drop_ready_c: got %0b expected 1", i2.src_ready_out); end
        i2.src_data_in = 16'd40; tick();
        tests_run++; if (i2.dst_valid_out !== 1'b1) begin tests_failed++; $display("FAIL drop_valid_d: got %0b expected 1", i2.dst_valid_out); end
        tests_run++; if (i2.dst_data_out !== 16'd30) begin tests_failed++; $display("FAIL drop_data_d: got %0d expected 30", $signed(i2.dst_data_out)); end
        i2.src_valid_in = 1'b0; tick();
        tests_run++; if (i2.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL drop_drain: got %0b expected 0", i2.dst_valid_out); end
    endtask

    task automatic test_avg_f4();
        int g1[4] = '{4, 8, 12, 16};
        int g2[4] = '{-3, -2, -1, -1};
        avg4 = 1'b1; i4.dst_ready_in = 1'b1; i4.src_valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i4.src_data_in = 16'(g1[k]); tick();
            tests_run++; if (phase4 !== 2'((k + 1) % 4)) begin tests_failed++; $display("FAIL avg_phase_%0d: got %0d expected %0d", k, phase4, (k + 1) % 4); end
        end
        tests_run++; if (i4.dst_valid_out !== 1'b1) begin tests_failed++; $display("FAIL avg_valid_1: got %0b expected 1", i4.dst_valid_out); end
        tests_run++; if (i4.dst_data_out !== 16'd10) begin tests_failed++; $display("FAIL avg_data_1: got %0d expected 10", $signed(i4.dst_data_out)); end
        for (int k = 0; k < 4; k++) begin
            i4.src_data_in = 16'(g2[k]); tick();
            if (k == 0) begin
                tests_run++; if (i4.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL avg_consumed: got %0b expected 0", i4.dst_valid_out); end
            end
        end
        tests_run++; if (i4.dst_valid_out !== 1'b1) begin tests_failed++; $display("FAIL avg_valid_2: got %0b expected 1", i4.dst_valid_out); end
        tests_run++; if (i4.dst_data_out !== 16'(-2)) begin tests_failed++; $display("FAIL avg_data_neg: got %0d expected -2", $signed(i4.dst_data_out)); end
        i4.src_valid_in = 1'b0; tick();
        tests_run++; if (i4.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL avg_drain: got %0b expected 0", i4.dst_valid_out); end
    endtask

    task automatic test_backpressure_f2();
        avg2 = 1'b0; i2.dst_ready_in = 1'b0; i2.src_valid_in = 1'b1;
        i2.src_data_in = 16'd10; tick();
        i2.src_data_in = 16'd20; tick();
        tests_run++; if (i2.dst_data_out !== 16'd10) begin tests_failed++; $display("FAIL bp_pending: got %0d expected 10", $signed(i2.dst_data_out)); end
        i2.src_data_in = 16'd30; tick();
        tests_run++; if (phase2 !== 1'b1) begin tests_failed++; $display("FAIL bp_phase0_accept: got %0d expected 1", phase2); end
        tests_run++; if (i2.src_ready_out !== 1'b0) begin tests_failed++; $display("FAIL bp_stall: got %0b expected 0", i2.src_ready_out); end
        i2.src_data_in = 16'd40; tick();
        tests_run++; if (phase2 !== 1'b1) begin tests_failed++; $display("FAIL bp_phase_hold: got %0d expected 1", phase2); end
        tests_run++; if (i2.dst_valid_out !== 1'b1 || i2.dst_data_out !== 16'd10) begin tests_failed++; $display("FAIL bp_stable: got valid %0b data %0d expected valid 1 data 10", i2.dst_valid_out, $signed(i2.dst_data_out)); end
        i2.dst_ready_in = 1'b1; #1;
        tests_run++; if (i2.src_ready_out !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %0b expected 1", i2.src_ready_out); end
        tick();
        tests_run++; if (i2.dst_valid_out !== 1'b1) begin tests_failed++; $display("FAIL bp_no_bubble: got %0b expected 1", i2.dst_valid_out); end
        tests_run++; if (i2.dst_data_out !== 16'd30) begin tests_failed++; $display("FAIL bp_reload: got %0d expected 30", $signed(i2.dst_data_out)); end
        i2.src_valid_in = 1'b0; tick();
        tests_run++; if (i2.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %0b expected 0", i2.dst_valid_out); end
    endtask

    task automatic test_flush_f4();
        avg4 = 1'b1; i4.dst_ready_in = 1'b0; i4.src_valid_in = 1'b1;
        i4.src_data_in = 16'd8;
        repeat (4) tick();
        tests_run++; if (i4.dst_data_out !== 16'd8) begin tests_failed++; $display("FAIL fl_pending: got %0d expected 8", $signed(i4.dst_data_out)); end
        i4.src_data_in = 16'd1; tick();
        i4.src_data_in = 16'd2; tick();
        tests_run++; if (phase4 !== 2'd2) begin tests_failed++; $display("FAIL fl_phase_pre: got %0d expected 2", phase4); end
        flush4 = 1'b1; i4.src_data_in = 16'd99; tick();
        tests_run++; if (phase4 !== 2'd0) begin tests_failed++; $display("FAIL fl_phase_post: got %0d expected 0", phase4); end
        tests_run++; if (i4.dst_valid_out !== 1'b1 || i4.dst_data_out !== 16'd8) begin tests_failed++; $display("FAIL fl_keep_pending: got valid %0b data %0d expected valid 1 data 8", i4.dst_valid_out, $signed(i4.dst_data_out)); end
        flush4 = 1'b0; i4.src_data_in = 16'd5;
        repeat (3) tick();
        tests_run++; if (phase4 !== 2'd3) begin tests_failed++; $display("FAIL fl_phase_last: got %0d expected 3", phase4); end
        tests_run++; if (i4.src_ready_out !== 1'b0) begin tests_failed++; $display("FAIL fl_stall: got %0b expected 0", i4.src_ready_out); end
        i4.dst_ready_in = 1'b1; tick();
        tests_run++; if (i4.dst_valid_out !== 1'b1 || i4.dst_data_out !== 16'd5) begin tests_failed++; $display("FAIL fl_new_group: got valid %0b data %0d expected valid 1 data 5", i4.dst_valid_out, $signed(i4.dst_data_out)); end
        i4.src_valid_in = 1'b0; tick();
        tests_run++; if (i4.dst_valid_out !== 1'b0) begin tests_failed++; $display("FAIL fl_drain: got %0b expected 0", i4.dst_valid_out); end
    endtask

    task automatic test_mode_switch_f2();
        i2.dst_ready_in = 1'b1; i2.src_valid_in = 1'b1;
        avg2 = 1'b0; i2.src_data_in = 16'd7; tick();
        avg2 = 1'b1; i2.src_data_in = 16'd9; tick();
        tests_run++; if (i2.dst_data_out !== 16'd7) begin tests_failed++; $display("FAIL mode_drop_kept: got %0d expected 7", $signed(i2.dst_data_out)); end
        i2.src_data_in = 16'd3; tick();
        avg2 = 1'b0; i2.src_data_in = 16'd6; tick();
        tests_run++; if (i2.dst_data_out !== 16'd4) begin tests_failed++; $display("FAIL mode_avg_kept: got %0d expected 4", $signed(i2.dst_data_out)); end
        avg2 = 1'b1; i2.src_data_in = 16'(-4); tick();
        i2.src_data_in = 16'(-5); tick();
        tests_run++; if (i2.dst_data_out !== 16'(-5)) begin tests_failed++; $display("FAIL mode_avg_floor: got %0d expected -5", $signed(i2.dst_data_out)); end
        i2.src_valid_in = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        avg2 = 1'b0; i2.dst_ready_in = 1'b0; i2.src_valid_in = 1'b1;
        i2.src_data_in = 16'd1; tick();
        i2.src_data_in = 16'd2; tick();
        i2.src_data_in = 16'd3; tick();
        tests_run++; if (phase2 !== 1'b1 || i2.dst_valid_out !== 1'b1) begin tests_failed++; $display("FAIL rst_setup: got phase %0d valid %0b expected phase 1 valid 1", phase2, i2.dst_valid_out); end
        #2; arst_n = 1'b0; #1;
        tests_run++; if (i2.dst_valid_out !== 1'b0 || phase2 !== 1'b0) begin tests_failed++; $display("FAIL rst_async: got valid %0b phase %0d expected valid 0 phase 0", i2.dst_valid_out, phase2); end
        tests_run++; if (i2.dst_data_out !== 16'd0) begin tests_failed++; $display("FAIL rst_async_data: got %0d expected 0", $signed(i2.dst_data_out)); end
        i2.src_valid_in = 1'b0;
        tick(); tick();
        #2; arst_n = 1'b1;
        tick();
        tests_run++; if (i2.dst_valid_out !== 1'b0 || phase2 !== 1'b0) begin tests_failed++; $display("FAIL rst_no_stale: got valid %0b phase %0d expected valid 0 phase 0", i2.dst_valid_out, phase2); end
        i2.dst_ready_in = 1'b1; i2.src_valid_in = 1'b1;
        i2.src_data_in = 16'd11; tick();
        i2.src_data_in = 16'd12; tick();
        tests_run++; if (i2.dst_valid_out !== 1'b1 || i2.dst_data_out !== 16'd11) begin tests_failed++; $display("FAIL rst_fresh_group: got valid %0b data %0d expected valid 1 data 11", i2.dst_valid_out, $signed(i2.dst_data_out)); end
        i2.src_valid_in = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_drop_f2();
        test_avg_f4();
        test_backpressure_f2();
        test_flush_f4();
        test_mode_switch_f2();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decimator_stream.md
Name: decimator_stream

Overview:
- Streaming decimate-by-FACTOR block; the down-sampling counterpart of the interpolator datapath. It consumes FACTOR input samples per output sample.
- Sits between a sample source and a sink, with valid/ready handshakes on both sides.
- Two modes:
  - Drop: keep the first sample of each group.
  - Average: boxcar mean of the group.
- A phase counter sequences each group; a single output register carries the result.

Parameters:
DATA_W, 16, sample width in bits; two's-complement signed.
FACTOR, 2, decimation ratio; power of two, 2..256 (elaboration error otherwise).

Ports:
clk  in  1  clock
arst_n  in  1  reset, asynchronous, active-low
src_valid_in  in  1  input sample valid
src_ready_out  out  1  block can accept the input sample
src_data_in  in  DATA_W  input sample, signed
dst_valid_out  out  1  output sample valid
dst_ready_in  in  1  sink accepts the output sample
dst_data_out  out  DATA_W  decimated sample, signed
avg_en_in  in  1  1 = average mode, 0 = drop mode; sampled only at group start (phase 0)
flush_in  in  1  synchronous abort of the partial group
phase_out  out  log2(FACTOR)  current phase, for debug/status

Behaviour:
- Reset (arst_n low, asynchronous): phase=0, acc=0, mode register=0, dst_valid_out=0, dst_data_out=0. src_ready_out is 1 immediately after reset deassertion.
- Input accept: src_valid_in & src_ready_out. Output transfer: dst_valid_out & dst_ready_in.
- src_ready_out = (phase != FACTOR-1) | !dst_valid_out | dst_ready_in, combinational.
  - Only the group-completing sample can stall.
  - Never depends on src_valid_in.
- Controller states:
  - COLLECT: phase 0..FACTOR-2.
  - LAST: phase = FACTOR-1.
  - Output-register valid flag tracked independently of these states.
- Accept at phase 0:
  - mode register <= avg_en_in.
  - acc <= sign-extended sample.
  - Drop mode: hold register <= sample.
  - phase <= 1.
- Accept at 0 < phase < FACTOR-1: acc <= acc + sample (average mode only); phase <= phase+1.
- Accept at phase FACTOR-1:
  - dst_data_out <= (acc + sample) >>> log2(FACTOR) in average mode (floor rounding), or hold register in drop mode.
  - dst_valid_out <= 1; phase <= 0; acc cleared.
- Accumulator width: DATA_W + log2(FACTOR), signed. No overflow is possible; the result always fits DATA_W.
- Latency: output valid one cycle after the last sample of a group is accepted. Sustained throughput is 1 input/cycle when dst_ready_in=1.
- Output transfer without a new completing sample in the same cycle: dst_valid_out <= 0.
- Same-cycle transfer and completion: the register reloads and dst_valid_out stays 1; no bubble and no loss.
- dst_data_out and dst_valid_out hold stable while dst_valid_out=1 & dst_ready_in=0.
- flush_in=1:
  - phase <= 0, acc <= 0; any input accept in that cycle is discarded.
  - A pending dst_valid_out sample is kept and still delivered.
  - src_ready_out is unaffected.
- avg_en_in changes mid-group have no effect until the next phase 0.
- Reset mid-group or with output pending: all state is lost; no partial output emitted.

Decomposition:
- Shared package dsp_pkg holds:
  - the controller state enum (COLLECT, LAST), 1-bit encoding;
  - the function/constant computing PHASE_W = $clog2(FACTOR).
- Sub-module decimator_ctrl: phase counter, state, output-valid flag, src_ready_out, and load strobes (acc_clr, acc_add, out_load). It is the mirror of interpolator_ctrl.
- The top level holds the accumulator, hold register and output register.

Test Plan:
- Drop, FACTOR=2, dst_ready=1, inputs 10,20,30,40 back-to-back -> outputs 10,30, each 1 cycle after the 2nd/4th accept; src_ready_out stays 1.
- Average, FACTOR=4, inputs 4,8,12,16 then -3,-2,-1,-1 -> outputs 10 then -2 (sum -7 >>>2 floor).
- Backpressure, FACTOR=2, dst_ready=0 with output 10 pending: sample at phase 0 accepted; sample at phase 1 sees src_ready_out=0. Raise dst_ready -> 10 transfers and the new group completes the same cycle, dst_valid_out stays 1.
- flush_in at phase 2 of FACTOR=4 (inputs 1,2 accepted) -> phase_out=0, next inputs 5,5,5,5 -> output 5; a pending earlier output is still delivered.
- Mode switch: avg_en_in toggles at phase 1 -> current group finishes in its original mode; the next group uses the new mode.
- Reset asserted with phase=1 and dst_valid_out=1 -> dst_valid_out=0, phase_out=0 immediately; no stale output after release.
